// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: BCD digit type, FSM states,
// and the BCD field increment helpers used for both run counting and adjust.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam int SEC_MAX = 59;

  function automatic logic at_max(input bcd_pair_t v, input int max);
    return (v.tens == bcd_t'(max / 10)) && (v.ones == bcd_t'(max % 10));
  endfunction

  // Two-digit BCD increment that wraps to 00 after reaching max.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input int max);
    bcd_pair_t r;
    if (at_max(v, max)) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// Free-running divider producing single-cycle 1 Hz and 2 Hz strobes from clk.
// Strobes decode the registered count, so they are low while the count is 0.
module stopwatch_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_1hz,
  output logic tick_2hz
);

  localparam int CW = $clog2(DIV_1HZ);
  localparam logic [CW-1:0] LAST = CW'(DIV_1HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV_1HZ / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_1hz = (cnt == LAST);
  assign tick_2hz = (cnt == HALF) || (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause and per-field adjust. Optional lap freeze of
// the display digits is built when STOPWATCH_LAP_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | seconds advance on tick_1hz, minutes on seconds carry
// ST_PAUSED  | digits hold
// ST_ADJUST  | selected field steps on tick_2hz, blink toggles
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ = 100000000,
  parameter int MIN_MAX = 59
) (
  input  logic clk,
  input  logic RESET,
  input  logic PAUSE,
  input  logic ADJ,
  input  logic SEL,
`ifdef STOPWATCH_LAP_EN
  input  logic LAP,
  output logic lap_valid,
`endif
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic tick_1hz,
  output logic tick_2hz,
  output logic running,
  output logic blink,
  output logic wrap
);

  state_t    state;
  state_t    state_nxt;
  logic      run_nxt;
  logic      count_en;
  logic      adj_en;
  logic      at_rollover;
  bcd_pair_t mins;
  bcd_pair_t secs;
  bcd_pair_t mins_inc;
  bcd_pair_t secs_inc;
  bcd_pair_t disp_mins;
  bcd_pair_t disp_secs;

  stopwatch_prescaler #(
    .DIV_1HZ(DIV_1HZ)
  ) u_prescaler (
    .clk     (clk),
    .reset   (RESET),
    .tick_1hz(tick_1hz),
    .tick_2hz(tick_2hz)
  );

  // ADJ wins over a run tick arriving on the same cycle it is raised.
  always_comb begin
    run_nxt     = PAUSE ? ~running : running;
    count_en    = (state == ST_RUN) && !ADJ && tick_1hz;
    adj_en      = (state == ST_ADJUST) && tick_2hz;
    secs_inc    = bcd_inc(secs, SEC_MAX);
    mins_inc    = bcd_inc(mins, MIN_MAX);
    at_rollover = at_max(secs, SEC_MAX) && at_max(mins, MIN_MAX);
    if (ADJ) begin
      state_nxt = ST_ADJUST;
    end else if (run_nxt) begin
      state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_PAUSED;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= ST_RUN;
      running <= 1'b1;
      mins    <= '0;
      secs    <= '0;
      blink   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= run_nxt;
      wrap    <= count_en && at_rollover;

      if (count_en) begin
        secs <= secs_inc;
        if (at_max(secs, SEC_MAX)) begin
          mins <= mins_inc;
        end
      end else if (adj_en) begin
        if (SEL) begin
          secs <= secs_inc;
        end else begin
          mins <= mins_inc;
        end
      end

      if (state_nxt != ST_ADJUST) begin
        blink <= 1'b0;
      end else if (adj_en) begin
        blink <= ~blink;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  bcd_pair_t lap_mins;
  bcd_pair_t lap_secs;

  // Snapshot is taken only on the freezing pulse; the live count keeps going.
  always_ff @(posedge clk) begin
    if (RESET) begin
      lap_valid <= 1'b0;
      lap_mins  <= '0;
      lap_secs  <= '0;
    end else if (LAP) begin
      if (!lap_valid) begin
        lap_mins <= mins;
        lap_secs <= secs;
      end
      lap_valid <= ~lap_valid;
    end
  end

  assign disp_mins = lap_valid ? lap_mins : mins;
  assign disp_secs = lap_valid ? lap_secs : secs;
`else
  assign disp_mins = mins;
  assign disp_secs = secs;
`endif

  assign min_tens = disp_mins.tens;
  assign min_ones = disp_mins.ones;
  assign sec_tens = disp_secs.tens;
  assign sec_ones = disp_secs.ones;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with DIV_1HZ=4; a second
// instance with MIN_MAX=2 exercises the full-range rollover.
module tb_stopwatch_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RESET = 1'b1;
  logic PAUSE = 1'b0;
  logic ADJ   = 1'b0;
  logic SEL   = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic LAP = 1'b0;
  logic lap_valid, lap_valid2;
`endif

  logic [3:0] mt, mo, st, so;
  logic [3:0] mt2, mo2, st2, so2;
  logic tick_1hz, tick_2hz, running, blink, wrap;
  logic tick_1hz2, tick_2hz2, running2, blink2, wrap2;

  stopwatch_core #(.DIV_1HZ(4), .MIN_MAX(59)) dut (
    .clk(clk), .RESET(RESET), .PAUSE(PAUSE), .ADJ(ADJ), .SEL(SEL),
`ifdef STOPWATCH_LAP_EN
    .LAP(LAP), .lap_valid(lap_valid),
`endif
    .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .running(running),
    .blink(blink), .wrap(wrap)
  );

  stopwatch_core #(.DIV_1HZ(4), .MIN_MAX(2)) dut2 (
    .clk(clk), .RESET(RESET), .PAUSE(PAUSE), .ADJ(ADJ), .SEL(SEL),
`ifdef STOPWATCH_LAP_EN
    .LAP(LAP), .lap_valid(lap_valid2),
`endif
    .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
    .tick_1hz(tick_1hz2), .tick_2hz(tick_2hz2), .running(running2),
    .blink(blink2), .wrap(wrap2)
  );

  int errors = 0;
  int checks = 0;
  int wrap_cnt = 0;
  int wrap2_cnt = 0;
  int base;

  always @(posedge clk) begin
    if (wrap === 1'b1) wrap_cnt <= wrap_cnt + 1;
    if (wrap2 === 1'b1) wrap2_cnt <= wrap2_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_1hz(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (tick_1hz !== 1'b1 && k < 40);
      if (tick_1hz !== 1'b1) check("tick_1hz_timeout", {15'd0, tick_1hz}, 16'd1);
    end
    @(negedge clk);
  endtask

  task automatic wait_2hz(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (tick_2hz !== 1'b1 && k < 40);
      if (tick_2hz !== 1'b1) check("tick_2hz_timeout", {15'd0, tick_2hz}, 16'd1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    do_reset();
    check("reset_digits", {mt, mo, st, so}, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd1);
    check("reset_blink", {15'd0, blink}, 16'd0);
    check("reset_wrap", {15'd0, wrap}, 16'd0);
    check("reset_ticks", {14'd0, tick_1hz, tick_2hz}, 16'd0);

    base = wrap_cnt;
    wait_1hz(60);
    check("run_60s_digits", {mt, mo, st, so}, 16'h0100);
    check("run_60s_running", {15'd0, running}, 16'd1);
    check("run_60s_no_wrap", 16'(wrap_cnt - base), 16'd0);
    check("presc_cnt0_ticks", {14'd0, tick_1hz, tick_2hz}, 16'd0);
    @(negedge clk);
    check("presc_half_ticks", {14'd0, tick_1hz, tick_2hz}, 16'd1);
    @(negedge clk);
    check("presc_cnt2_ticks", {14'd0, tick_1hz, tick_2hz}, 16'd0);

    base = wrap2_cnt;
    wait_1hz(119);
    check("mm2_259_digits", {mt2, mo2, st2, so2}, 16'h0259);
    check("mm2_no_early_wrap", 16'(wrap2_cnt - base), 16'd0);
    wait_1hz(1);
    check("mm2_rollover_digits", {mt2, mo2, st2, so2}, 16'h0000);
    check("mm2_wrap_high", {15'd0, wrap2}, 16'd1);
    check("mm59_at_300", {mt, mo, st, so}, 16'h0300);
    @(negedge clk);
    check("mm2_wrap_low", {15'd0, wrap2}, 16'd0);
    check("mm2_wrap_once", 16'(wrap2_cnt - base), 16'd1);

    do_reset();
    wait_1hz(5);
    check("pause_pre_digits", {mt, mo, st, so}, 16'h0005);
    PAUSE = 1'b1;
    @(negedge clk);
    PAUSE = 1'b0;
    check("pause_running_off", {15'd0, running}, 16'd0);
    wait_1hz(10);
    check("pause_hold_digits", {mt, mo, st, so}, 16'h0005);
    PAUSE = 1'b1;
    @(negedge clk);
    PAUSE = 1'b0;
    check("pause_running_on", {15'd0, running}, 16'd1);
    wait_1hz(1);
    check("resume_digits", {mt, mo, st, so}, 16'h0006);

    wait_1hz(52);
    check("adj_pre_digits", {mt, mo, st, so}, 16'h0058);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tick_1hz !== 1'b1 && k < 40);
    ADJ = 1'b1;
    SEL = 1'b1;
    @(negedge clk);
    check("adj_priority_digits", {mt, mo, st, so}, 16'h0058);
    check("adj_entry_blink", {15'd0, blink}, 16'd0);
    wait_2hz(1);
    check("adj_sec_59", {mt, mo, st, so}, 16'h0059);
    check("adj_blink_1", {15'd0, blink}, 16'd1);
    wait_2hz(1);
    check("adj_sec_wrap_00", {mt, mo, st, so}, 16'h0000);
    check("adj_blink_2", {15'd0, blink}, 16'd0);
    wait_2hz(1);
    check("adj_sec_01", {mt, mo, st, so}, 16'h0001);
    check("adj_blink_3", {15'd0, blink}, 16'd1);
    SEL = 1'b0;
    wait_2hz(1);
    check("adj_min_01", {mt, mo, st, so}, 16'h0101);
    wait_2hz(1);
    check("adj_min_02", {mt, mo, st, so}, 16'h0201);
    check("adj_blink_5", {15'd0, blink}, 16'd1);
    ADJ = 1'b0;
    @(negedge clk);
    check("adj_exit_blink", {15'd0, blink}, 16'd0);
    check("adj_exit_digits", {mt, mo, st, so}, 16'h0201);
    @(negedge clk);
    check("adj_exit_resume", {mt, mo, st, so}, 16'h0202);

    do_reset();
    ADJ = 1'b1;
    SEL = 1'b0;
    wait_2hz(3);
    check("adj_set_min_3", {mt, mo, st, so}, 16'h0300);
    SEL = 1'b1;
    wait_2hz(20);
    check("adj_set_320", {mt, mo, st, so}, 16'h0320);
    check("adj_320_blink", {15'd0, blink}, 16'd1);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    ADJ = 1'b0;
    check("adj_reset_digits", {mt, mo, st, so}, 16'h0000);
    check("adj_reset_blink", {15'd0, blink}, 16'd0);
    check("adj_reset_running", {15'd0, running}, 16'd1);
    wait_1hz(1);
    check("adj_reset_runs", {mt, mo, st, so}, 16'h0001);

`ifdef STOPWATCH_LAP_EN
    do_reset();
    wait_1hz(10);
    check("lap_pre_digits", {mt, mo, st, so}, 16'h0010);
    LAP = 1'b1;
    @(negedge clk);
    LAP = 1'b0;
    check("lap_valid_set", {15'd0, lap_valid}, 16'd1);
    wait_1hz(5);
    check("lap_frozen_digits", {mt, mo, st, so}, 16'h0010);
    LAP = 1'b1;
    @(negedge clk);
    LAP = 1'b0;
    check("lap_release_digits", {mt, mo, st, so}, 16'h0015);
    check("lap_valid_clear", {15'd0, lap_valid}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Param DIV_1HZ, default 100000000, clk cycles per second; SHALL be even and >=4.
REQ-002 Param MIN_MAX, default 59, highest minutes value (1..99) before wrap.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 PAUSE  input  1  single-cycle pulse (debounced upstream); toggles run flag.
REQ-006 ADJ  input  1  level; 1 = adjust mode.
REQ-007 SEL  input  1  adjust field select: 0 = minutes, 1 = seconds.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits.
REQ-009 tick_1hz, tick_2hz  output  1  single-cycle strobes from prescaler.
REQ-010 running  output  1  run flag.
REQ-011 blink  output  1  toggles in adjust mode for display flashing of selected field.
REQ-012 wrap  output  1  single-cycle pulse on MIN_MAX:59 -> 00:00 run rollover.

Function
REQ-013 Prescaler SHALL free-run 0..DIV_1HZ-1, unaffected by PAUSE/ADJ; tick_1hz at count DIV_1HZ-1; tick_2hz at DIV_1HZ/2-1 and DIV_1HZ-1.
REQ-014 FSM states RUN, PAUSED, ADJUST; ADJ=1 -> ADJUST next cycle; ADJ=0 in ADJUST -> RUN if run flag=1, else PAUSED.
REQ-015 PAUSE pulse SHALL toggle run flag in every state, including ADJUST; RUN<->PAUSED follows flag.
REQ-016 RUN: on tick_1hz, sec_ones 0..9, carry into sec_tens 0..5; 59 s -> 00 s with carry into minutes.
REQ-017 Minutes SHALL count 0..MIN_MAX in BCD; at MIN_MAX:59 next tick -> 00:00 and wrap=1 for that cycle.
REQ-018 PAUSED: digits SHALL hold.
REQ-019 ADJUST: on tick_2hz, selected field +1; seconds wrap 59->00 and minutes wrap MIN_MAX->00, no carry; unselected field holds.
REQ-020 ADJUST: tick_1hz SHALL NOT advance time; ADJ priority over run count on the same cycle.
REQ-021 blink SHALL toggle on each tick_2hz while ADJUST; forced 0 outside ADJUST.
REQ-022 Output digits registered; update one cycle after triggering strobe.
REQ-023 SEL change mid-ADJUST SHALL take effect at the next tick_2hz.

Reset
REQ-024 RESET SHALL override all inputs: digits 0, prescaler 0, run flag 1, state RUN, blink 0, wrap 0, ticks 0.
REQ-025 RESET mid-ADJUST or mid-lap SHALL return to RUN at 00:00 the following cycle.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN: when defined, input LAP (1-bit pulse) and output lap_valid (1-bit) exist.
REQ-027 With macro: first LAP pulse freezes digit outputs at current value, lap_valid=1, internal count continues; next LAP pulse releases outputs to live count, lap_valid=0.
REQ-028 Without macro: no LAP/lap_valid ports; digits always live.

Structure
REQ-029 Package stopwatch_pkg: 4-bit BCD digit type, FSM state enum, constant SEC_MAX=59.
REQ-030 Sub-module stopwatch_prescaler (DIV_1HZ param) SHALL generate tick_1hz/tick_2hz.

Verification (DIV_1HZ=4)
REQ-031 Reset, 60 tick_1hz -> 01:00, running=1, wrap never asserted.
REQ-032 MIN_MAX=2, 179 ticks -> 02:59; next tick -> 00:00 with wrap=1 for exactly one cycle.
REQ-033 PAUSE pulse at 00:05, 10 ticks -> holds 00:05; second PAUSE -> next tick 00:06.
REQ-034 At 00:58, ADJ=1 SEL=1, 3 tick_2hz -> 00:59, 00:00, 00:01; minutes 00; blink toggles per tick_2hz; ADJ asserted on tick_1hz cycle -> no run increment.
REQ-035 LAP build: LAP at 00:10, 5 ticks -> outputs 00:10, lap_valid=1; LAP again -> 00:15, lap_valid=0.
REQ-036 RESET during ADJUST at 03:20 -> 00:00, state RUN, blink 0.
